// File: rtl/i2c_target.sv
// I2C target endpoint: fixed 7-bit address, multi-byte write capture
// into a flat buffer and multi-byte read from a flat input vector.
module i2c_target #(
   parameter logic [6:0] addr_g        = 7'h50,
   parameter int         nbytes_g      = 3,
   parameter int         sync_stages_g = 2
) (
   input  logic                          clk_i,
   input  logic                          rst_i,
   input  logic                          scl_i,
   inout  wire                           sda_io,
   input  logic [nbytes_g*8-1:0]         tx_data_i,
   output logic [nbytes_g*8-1:0]         rx_data_o,
   output logic [$clog2(nbytes_g+1)-1:0] rx_count_o,
   output logic                          rw_o,
   output logic                          busy_o,
   output logic                          done_o
);

   localparam int CW = $clog2(nbytes_g+1);
   localparam logic [CW-1:0] NB = CW'(nbytes_g);

   typedef enum logic [2:0] {
      S_IDLE,
      S_ADDR,
      S_ADDR_ACK,
      S_RX,
      S_RX_ACK,
      S_TX,
      S_TX_ACK,
      S_WAIT_STOP
   } state_t;

   logic [sync_stages_g-1:0] r_scl_sync;
   logic [sync_stages_g-1:0] r_sda_sync;
   logic                     r_scl_d;
   logic                     r_sda_d;

   state_t               r_state,   w_state_nxt;
   logic [3:0]           r_bitcnt,  w_bitcnt_nxt;
   logic [6:0]           r_shift,   w_shift_nxt;
   logic [6:0]           r_txsh,    w_txsh_nxt;
   logic [CW-1:0]        r_idx,     w_idx_nxt;
   logic [CW-1:0]        r_rx_cnt,  w_rx_cnt_nxt;
   logic [nbytes_g*8-1:0] r_rx_data, w_rx_data_nxt;
   logic                 r_sda_oe,  w_sda_oe_nxt;
   logic                 r_rw,      w_rw_nxt;
   logic                 r_busy,    w_busy_nxt;
   logic                 r_done,    w_done_nxt;

   logic       w_scl;
   logic       w_sda;
   logic       w_rise;
   logic       w_fall;
   logic       w_start;
   logic       w_stop;
   logic [7:0] w_byte_in;
   logic [7:0] w_tx_byte;

   // Reset loads the live bus levels so leaving reset creates no edges.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_scl_sync <= {sync_stages_g{scl_i}};
         r_sda_sync <= {sync_stages_g{sda_io}};
         r_scl_d    <= scl_i;
         r_sda_d    <= sda_io;
      end else begin
         r_scl_sync <= {r_scl_sync[sync_stages_g-2:0], scl_i};
         r_sda_sync <= {r_sda_sync[sync_stages_g-2:0], sda_io};
         r_scl_d    <= r_scl_sync[sync_stages_g-1];
         r_sda_d    <= r_sda_sync[sync_stages_g-1];
      end
   end

   assign w_scl     = r_scl_sync[sync_stages_g-1];
   assign w_sda     = r_sda_sync[sync_stages_g-1];
   assign w_rise    = w_scl & ~r_scl_d;
   assign w_fall    = ~w_scl & r_scl_d;
   assign w_start   = w_scl & r_scl_d & r_sda_d & ~w_sda;
   assign w_stop    = w_scl & r_scl_d & ~r_sda_d & w_sda;
   assign w_byte_in = {r_shift, w_sda};

   always_comb begin
      w_tx_byte = 8'hFF;
      for (int k = 0; k < nbytes_g; k++) begin
         if (r_idx == CW'(k)) w_tx_byte = tx_data_i[k*8 +: 8];
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state   <= S_IDLE;
         r_bitcnt  <= '0;
         r_shift   <= '0;
         r_txsh    <= '0;
         r_idx     <= '0;
         r_rx_cnt  <= '0;
         r_rx_data <= '0;
         r_sda_oe  <= 1'b0;
         r_rw      <= 1'b0;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_bitcnt  <= w_bitcnt_nxt;
         r_shift   <= w_shift_nxt;
         r_txsh    <= w_txsh_nxt;
         r_idx     <= w_idx_nxt;
         r_rx_cnt  <= w_rx_cnt_nxt;
         r_rx_data <= w_rx_data_nxt;
         r_sda_oe  <= w_sda_oe_nxt;
         r_rw      <= w_rw_nxt;
         r_busy    <= w_busy_nxt;
         r_done    <= w_done_nxt;
      end
   end

   always_comb begin
      w_state_nxt   = r_state;
      w_bitcnt_nxt  = r_bitcnt;
      w_shift_nxt   = r_shift;
      w_txsh_nxt    = r_txsh;
      w_idx_nxt     = r_idx;
      w_rx_cnt_nxt  = r_rx_cnt;
      w_rx_data_nxt = r_rx_data;
      w_sda_oe_nxt  = r_sda_oe;
      w_rw_nxt      = r_rw;
      w_busy_nxt    = r_busy;
      w_done_nxt    = 1'b0;

      if (w_start) begin
         w_state_nxt  = S_ADDR;
         w_bitcnt_nxt = '0;
         w_sda_oe_nxt = 1'b0;
      end else if (w_stop) begin
         w_state_nxt  = S_IDLE;
         w_bitcnt_nxt = '0;
         w_sda_oe_nxt = 1'b0;
         w_done_nxt   = r_busy;
         w_busy_nxt   = 1'b0;
      end else begin
         case (r_state)
            S_ADDR: begin
               if (w_rise) begin
                  w_shift_nxt  = w_byte_in[6:0];
                  w_bitcnt_nxt = r_bitcnt + 4'd1;
                  if (r_bitcnt == 4'd7) begin
                     w_bitcnt_nxt = '0;
                     if (w_byte_in[7:1] == addr_g) begin
                        w_rw_nxt    = w_byte_in[0];
                        w_busy_nxt  = 1'b1;
                        w_idx_nxt   = '0;
                        w_state_nxt = S_ADDR_ACK;
                     end else begin
                        w_state_nxt = S_WAIT_STOP;
                     end
                  end
               end
            end
            // First falling edge starts the ACK, the next one ends it.
            S_ADDR_ACK: begin
               if (w_fall) begin
                  if (!r_sda_oe) begin
                     w_sda_oe_nxt = 1'b1;
                  end else if (r_rw) begin
                     w_txsh_nxt   = w_tx_byte[6:0];
                     w_sda_oe_nxt = ~w_tx_byte[7];
                     w_bitcnt_nxt = '0;
                     w_state_nxt  = S_TX;
                  end else begin
                     w_sda_oe_nxt = 1'b0;
                     w_rx_cnt_nxt = '0;
                     w_state_nxt  = S_RX;
                  end
               end
            end
            S_RX: begin
               if (w_rise) begin
                  w_shift_nxt  = w_byte_in[6:0];
                  w_bitcnt_nxt = r_bitcnt + 4'd1;
                  if (r_bitcnt == 4'd7) begin
                     w_bitcnt_nxt = '0;
                     if (r_rx_cnt < NB) begin
                        for (int k = 0; k < nbytes_g; k++) begin
                           if (r_rx_cnt == CW'(k))
                              w_rx_data_nxt[k*8 +: 8] = w_byte_in;
                        end
                        w_rx_cnt_nxt = r_rx_cnt + 1'b1;
                        w_state_nxt  = S_RX_ACK;
                     end else begin
                        w_sda_oe_nxt = 1'b0;
                        w_state_nxt  = S_WAIT_STOP;
                     end
                  end
               end
            end
            S_RX_ACK: begin
               if (w_fall) begin
                  if (!r_sda_oe) begin
                     w_sda_oe_nxt = 1'b1;
                  end else begin
                     w_sda_oe_nxt = 1'b0;
                     w_state_nxt  = S_RX;
                  end
               end
            end
            S_TX: begin
               if (w_rise) begin
                  w_bitcnt_nxt = r_bitcnt + 4'd1;
               end else if (w_fall) begin
                  if (r_bitcnt == 4'd8) begin
                     w_bitcnt_nxt = '0;
                     w_sda_oe_nxt = 1'b0;
                     w_state_nxt  = S_TX_ACK;
                  end else begin
                     w_sda_oe_nxt = ~r_txsh[6];
                     w_txsh_nxt   = {r_txsh[5:0], 1'b0};
                  end
               end
            end
            S_TX_ACK: begin
               if (w_rise) begin
                  if (w_sda) begin
                     w_state_nxt = S_WAIT_STOP;
                  end else if (r_idx < NB) begin
                     w_idx_nxt = r_idx + 1'b1;
                  end
               end else if (w_fall) begin
                  w_txsh_nxt   = w_tx_byte[6:0];
                  w_sda_oe_nxt = ~w_tx_byte[7];
                  w_bitcnt_nxt = '0;
                  w_state_nxt  = S_TX;
               end
            end
            default: begin
            end
         endcase
      end
   end

   // Release is combinational on rst_i so the bus frees immediately.
   assign sda_io     = (r_sda_oe && !rst_i) ? 1'b0 : 1'bz;
   assign rx_data_o  = r_rx_data;
   assign rx_count_o = r_rx_cnt;
   assign rw_o       = r_rw;
   assign busy_o     = r_busy;
   assign done_o     = r_done;

endmodule

// File: tb/tb_i2c_target.sv
// Directed bench for i2c_target: write table plus read, repeated
// START, overflow and mid-transfer reset sequences.
`timescale 1ns/1ps
module tb_i2c_target;

   localparam int Q = 4;

   logic        clk   = 1'b0;
   logic        rst   = 1'b1;
   logic        scl   = 1'b1;
   logic        m_rel = 1'b1;
   logic [23:0] tx    = '0;
   wire         sda;
   logic [23:0] rx;
   logic [1:0]  cnt;
   logic        rw;
   logic        busy;
   logic        done;

   pullup (sda);
   assign sda = m_rel ? 1'bz : 1'b0;

   always #5 clk = ~clk;

   i2c_target #(
      .addr_g(7'h50),
      .nbytes_g(3),
      .sync_stages_g(2)
   ) dut (
      .clk_i(clk),
      .rst_i(rst),
      .scl_i(scl),
      .sda_io(sda),
      .tx_data_i(tx),
      .rx_data_o(rx),
      .rx_count_o(cnt),
      .rw_o(rw),
      .busy_o(busy),
      .done_o(done)
   );

   int   checks    = 0;
   int   failures  = 0;
   int   done_cnt  = 0;
   int   busy_bad  = 0;
   logic prev_busy = 1'b0;

   always @(negedge clk) begin
      if (done) begin
         done_cnt++;
         if (busy || !prev_busy) busy_bad++;
      end
      prev_busy = busy;
   end

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic bit_io(input logic b, output logic s);
      tick(Q);
      m_rel = b;
      tick(Q);
      scl = 1'b1;
      tick(Q);
      s = sda;
      tick(Q);
      scl = 1'b0;
   endtask

   task automatic start_c();
      m_rel = 1'b1;
      tick(Q);
      scl = 1'b1;
      tick(Q);
      m_rel = 1'b0;
      tick(Q);
      scl = 1'b0;
   endtask

   task automatic stop_c();
      m_rel = 1'b0;
      tick(Q);
      scl = 1'b1;
      tick(Q);
      m_rel = 1'b1;
      tick(2*Q);
   endtask

   task automatic send_byte(input logic [7:0] b, output logic ack);
      logic s;
      for (int i = 7; i >= 0; i--) bit_io(b[i], s);
      bit_io(1'b1, s);
      ack = ~s;
   endtask

   task automatic recv_byte(input logic mack, output logic [7:0] b,
                            output logic slot);
      logic s;
      for (int i = 7; i >= 0; i--) begin
         bit_io(1'b1, s);
         b[i] = s;
      end
      bit_io(~mack, s);
      slot = s;
   endtask

   typedef struct {
      int          n;
      logic [39:0] b;
      logic [4:0]  ack;
      logic [23:0] rx;
      logic [1:0]  cnt;
      logic        rw;
      int          dn;
   } wvec_t;

   wvec_t       tbl[3];
   logic        a;
   logic        s;
   logic [7:0]  rb;
   int          d0;

   initial begin
      #1ms;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      tbl[0] = '{3, {16'h0, 8'h34, 8'h12, 8'hA0}, 5'b00111,
                 24'h003412, 2'd2, 1'b0, 1};
      tbl[1] = '{3, {16'h0, 8'h34, 8'h12, 8'hA2}, 5'b00000,
                 24'h003412, 2'd2, 1'b0, 0};
      tbl[2] = '{5, {8'h04, 8'h03, 8'h02, 8'h01, 8'hA0}, 5'b01111,
                 24'h030201, 2'd3, 1'b0, 1};

      tick(5);
      chk("rst_rx", 32'(rx), 32'h0);
      chk("rst_cnt", 32'(cnt), 32'h0);
      chk("rst_flags", 32'({rw, busy, done}), 32'h0);
      chk("rst_sda", 32'(sda), 32'h1);
      rst = 1'b0;
      tick(5);

      for (int i = 0; i < 3; i++) begin
         d0 = done_cnt;
         start_c();
         for (int j = 0; j < tbl[i].n; j++) begin
            send_byte(tbl[i].b[j*8 +: 8], a);
            chk($sformatf("w%0d_ack%0d", i, j), 32'(a),
                32'(tbl[i].ack[j]));
         end
         stop_c();
         chk($sformatf("w%0d_rx", i), 32'(rx), 32'(tbl[i].rx));
         chk($sformatf("w%0d_cnt", i), 32'(cnt), 32'(tbl[i].cnt));
         chk($sformatf("w%0d_rw", i), 32'(rw), 32'(tbl[i].rw));
         chk($sformatf("w%0d_done", i), 32'(done_cnt - d0),
             32'(tbl[i].dn));
         chk($sformatf("w%0d_busy", i), 32'(busy), 32'h0);
      end

      tx = 24'hCCBBAA;
      d0 = done_cnt;
      start_c();
      send_byte(8'hA1, a);
      chk("rd_addr_ack", 32'(a), 32'h1);
      recv_byte(1'b1, rb, s);
      chk("rd_b0", 32'(rb), 32'hAA);
      recv_byte(1'b1, rb, s);
      chk("rd_b1", 32'(rb), 32'hBB);
      recv_byte(1'b0, rb, s);
      chk("rd_b2", 32'(rb), 32'hCC);
      chk("rd_nack_slot", 32'(s), 32'h1);
      chk("rd_rw", 32'(rw), 32'h1);
      stop_c();
      chk("rd_done", 32'(done_cnt - d0), 32'h1);
      chk("rd_busy", 32'(busy), 32'h0);

      d0 = done_cnt;
      start_c();
      send_byte(8'hA0, a);
      chk("rs_waddr_ack", 32'(a), 32'h1);
      send_byte(8'h55, a);
      chk("rs_wdata_ack", 32'(a), 32'h1);
      start_c();
      send_byte(8'hA1, a);
      chk("rs_raddr_ack", 32'(a), 32'h1);
      recv_byte(1'b0, rb, s);
      chk("rs_rbyte", 32'(rb), 32'hAA);
      chk("rs_nack_slot", 32'(s), 32'h1);
      stop_c();
      chk("rs_rx", 32'(rx), 32'h030255);
      chk("rs_cnt", 32'(cnt), 32'h1);
      chk("rs_rw", 32'(rw), 32'h1);
      chk("rs_done", 32'(done_cnt - d0), 32'h1);

      tx = 24'h0000F0;
      start_c();
      send_byte(8'hA1, a);
      chk("rr_addr_ack", 32'(a), 32'h1);
      for (int k = 0; k < 4; k++) bit_io(1'b1, s);
      tick(Q);
      scl = 1'b1;
      tick(Q);
      chk("rr_pre_sda", 32'(sda), 32'h0);
      rst = 1'b1;
      tick(1);
      chk("rr_sda", 32'(sda), 32'h1);
      chk("rr_rx", 32'(rx), 32'h0);
      chk("rr_cnt", 32'(cnt), 32'h0);
      chk("rr_flags", 32'({rw, busy, done}), 32'h0);
      rst = 1'b0;
      tick(Q);
      scl = 1'b0;
      tick(Q);
      stop_c();
      d0 = done_cnt;
      start_c();
      send_byte(8'hA0, a);
      chk("rw_addr_ack", 32'(a), 32'h1);
      send_byte(8'h11, a);
      chk("rw_ack0", 32'(a), 32'h1);
      send_byte(8'h22, a);
      chk("rw_ack1", 32'(a), 32'h1);
      send_byte(8'h33, a);
      chk("rw_ack2", 32'(a), 32'h1);
      stop_c();
      chk("rw_rx", 32'(rx), 32'h332211);
      chk("rw_cnt", 32'(cnt), 32'h3);
      chk("rw_rw", 32'(rw), 32'h0);
      chk("rw_done", 32'(done_cnt - d0), 32'h1);
      chk("busy_vs_done", 32'(busy_bad), 32'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
